// File: rtl/roberto_rx_servo_cmd.sv
// -----------------------------------------------------------------------------
// roberto_rx_servo_cmd
// Assembles 3-byte servo command frames [ID][POS][END] from the serial
// receiver byte stream, validates them and updates the addressed servo
// position register. Malformed frames and inter-byte timeouts are discarded
// and reported with a one-cycle error pulse.
//
// Ports
//   clock        in   1            system clock
//   reset        in   1            synchronous, active-high
//   zera_servos  in   1            pulse: restore all positions, abort frame
//   dado_rx      in   8            received byte, valid when pronto_rx=1
//   pronto_rx    in   1            one-cycle pulse per received byte
//   posicoes     out  8*N_SERVOS   packed positions, servo k at [8k+7:8k]
//   frame_ok     out  1            one-cycle pulse: valid frame applied
//   frame_err    out  1            one-cycle pulse: frame rejected
//   ocupado      out  1            high while a frame is partially received
//   db_estado    out  3            current FSM state code
// -----------------------------------------------------------------------------
module roberto_rx_servo_cmd #(
   parameter int         N_SERVOS    = 2,
   parameter logic [7:0] POS_MAX     = 8'd180,
   parameter logic [7:0] POS_DEFAULT = 8'd90,
   parameter logic [7:0] END_CHAR    = 8'h23,
   parameter int         TIMEOUT     = 50_000_000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  zera_servos,
   input  logic [7:0]            dado_rx,
   input  logic                  pronto_rx,
   output logic [8*N_SERVOS-1:0] posicoes,
   output logic                  frame_ok,
   output logic                  frame_err,
   output logic                  ocupado,
   output logic [2:0]            db_estado
);

   localparam int         ID_W     = (N_SERVOS > 1) ? $clog2(N_SERVOS) : 1;
   localparam int         CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [7:0] ID_FIRST = 8'h30;
   localparam logic [7:0] ID_LAST  = 8'(32'h30 + N_SERVOS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ESPERA_ID  = 3'd0,
      ESPERA_POS = 3'd1,
      ESPERA_FIM = 3'd2,
      APLICA     = 3'd3,
      ERRO       = 3'd4
   } estado_t;

   estado_t          estado_r;
   estado_t          estado_s;
   logic [ID_W-1:0]  id_r;
   logic [7:0]       pos_r;
   logic [CNT_W-1:0] cnt_r;
   logic             latch_id_s;
   logic             latch_pos_s;
   logic             cnt_clr_s;

   // True when the byte addresses an existing servo ('0'..'0'+N_SERVOS-1).
   function automatic logic id_valid(input logic [7:0] b);
      if ((b >= ID_FIRST) && (b <= ID_LAST)) begin
         return 1'b1;
      end else begin
         return 1'b0;
      end
   endfunction

   // Next-state decode. The counter only runs while waiting mid-frame; a
   // byte arriving on the timeout cycle is processed instead of timing out.
   always_comb begin
      estado_s    = ESPERA_ID;
      latch_id_s  = 1'b0;
      latch_pos_s = 1'b0;
      cnt_clr_s   = 1'b1;
      case (estado_r)
         ESPERA_ID: begin
            if (pronto_rx) begin
               if (id_valid(dado_rx)) begin
                  estado_s   = ESPERA_POS;
                  latch_id_s = 1'b1;
               end else begin
                  estado_s = ERRO;
               end
            end else begin
               estado_s = ESPERA_ID;
            end
         end
         ESPERA_POS: begin
            if (pronto_rx) begin
               if (dado_rx <= POS_MAX) begin
                  estado_s    = ESPERA_FIM;
                  latch_pos_s = 1'b1;
               end else begin
                  estado_s = ERRO;
               end
            end else if (cnt_r == CNT_LAST) begin
               estado_s = ERRO;
            end else begin
               estado_s  = ESPERA_POS;
               cnt_clr_s = 1'b0;
            end
         end
         ESPERA_FIM: begin
            if (pronto_rx) begin
               if (dado_rx == END_CHAR) begin
                  estado_s = APLICA;
               end else begin
                  estado_s = ERRO;
               end
            end else if (cnt_r == CNT_LAST) begin
               estado_s = ERRO;
            end else begin
               estado_s  = ESPERA_FIM;
               cnt_clr_s = 1'b0;
            end
         end
         APLICA: begin
            estado_s = ESPERA_ID;
         end
         ERRO: begin
            estado_s = ESPERA_ID;
         end
         default: begin
            estado_s = ESPERA_ID;
         end
      endcase
   end

   // State register with Moore outputs registered from the next state.
   always_ff @(posedge clock) begin
      if (reset || zera_servos) begin
         estado_r  <= ESPERA_ID;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         ocupado   <= 1'b0;
      end else begin
         estado_r  <= estado_s;
         frame_ok  <= (estado_s == APLICA);
         frame_err <= (estado_s == ERRO);
         ocupado   <= (estado_s == ESPERA_POS) || (estado_s == ESPERA_FIM);
      end
   end

   // Inter-byte timeout counter.
   always_ff @(posedge clock) begin
      if (reset || zera_servos) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_clr_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Holding registers for the frame under assembly.
   always_ff @(posedge clock) begin
      if (reset || zera_servos) begin
         id_r  <= {ID_W{1'b0}};
         pos_r <= 8'd0;
      end else begin
         if (latch_id_s) begin
            id_r <= ID_W'(dado_rx - ID_FIRST);
         end
         if (latch_pos_s) begin
            pos_r <= dado_rx;
         end
      end
   end

   // Servo position registers: only the addressed servo changes in APLICA.
   always_ff @(posedge clock) begin
      if (reset || zera_servos) begin
         for (int k = 0; k < N_SERVOS; k++) begin
            posicoes[8*k +: 8] <= POS_DEFAULT;
         end
      end else if (estado_r == APLICA) begin
         for (int k = 0; k < N_SERVOS; k++) begin
            if (id_r == ID_W'(k)) begin
               posicoes[8*k +: 8] <= pos_r;
            end
         end
      end
   end

   assign db_estado = estado_r;

endmodule
